uart_msg_tx: RTL and testbench
==============================

Name: uart_msg_tx

Overview:
Parametrised UART message transmitter. It streams a MSG_LEN-byte message, LSB first, over one TX line, using a configurable bit period, data width, parity and stop bits. The message bytes come from an external combinational lookup (msg_addr/msg_data), so the same block serves any ROM or register bank. It adds a start/busy/done handshake, an optional inter-message gap, and a continuous loop mode. It sits directly behind the user_module pin wrapper, driving io_out[0].

Parameters:
CLKS_PER_BIT, 1, clock cycles per UART bit (>=1)
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
MSG_LEN, 13, bytes per message (1..256)
GAP_FRAMES, 1, idle frame-lengths after each message (0..15)
ADDR_W, 4, msg_addr width; requires 2**ADDR_W >= MSG_LEN

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request one message; sampled only in IDLE
loop  input  1  when high at end of gap, restart the message without returning to IDLE
msg_data  input  8  byte at msg_addr, combinational, valid in the same cycle; bits above DATA_BITS-1 ignored
msg_addr  output  ADDR_W  index of the byte being or about to be sent
busy  output  1  high from the cycle after start is accepted until return to IDLE
done  output  1  one-cycle pulse when a message plus its gap completes
uart_tx  output  1  serial line, registered, idle high

Behaviour:
- Reset: state=IDLE, uart_tx=1, busy=0, done=0, msg_addr=0, all counters 0. Reset mid-frame aborts at the next edge; no partial stop bit is sent.
- Frame: START(0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, then STOP_BITS x 1. FRAME_BITS = 1+DATA_BITS+(PARITY!=0)+STOP_BITS.
- Parity: even = XOR of data bits; odd = inverted XOR.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1. A bit advances when the count wraps, so every bit holds exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE: start=1 at edge N -> START at N+1. At that same edge msg_data is latched into the shift register; uart_tx=0 and busy=1 from N+1.
  - START -> DATA after 1 bit.
  - DATA -> PARITY (or STOP if PARITY=0) after DATA_BITS bits; the shift register shifts right once per bit.
  - PARITY -> STOP after 1 bit.
  - STOP, after STOP_BITS bits:
    - if msg_addr < MSG_LEN-1: msg_addr+1, reload the shift register, go to START. Back-to-back frames, no idle bits between bytes.
    - else: msg_addr=0 and go to GAP (skip GAP if GAP_FRAMES=0).
  - GAP: uart_tx=1 for GAP_FRAMES*FRAME_BITS*CLKS_PER_BIT cycles. At the end, done=1 for one cycle; then loop=1 -> START (reload byte 0, busy stays 1), else -> IDLE (busy=0 on the following cycle).
- start while busy is ignored; it is not queued. start and loop are sampled only at the decision points listed above.
- loop dropping mid-message does not abort; the message and its gap finish, then the block goes to IDLE.
- Latency: first falling edge of uart_tx 1 cycle after start. One message lasts (MSG_LEN + GAP_FRAMES) * FRAME_BITS * CLKS_PER_BIT cycles.
- MSG_LEN=1: STOP goes straight to GAP; msg_addr stays 0.
- Counter widths: sized with $clog2 of their maximum values plus 1; no wrap inside a valid frame.

Decomposition:
- Package uart_msg_tx_pkg holds:
  - parity localparams PAR_NONE/PAR_ODD/PAR_EVEN
  - the state typedef
  - a frame_bits(DATA_BITS,PARITY,STOP_BITS) constant function
- Sub-module uart_baud_tick: parameter CLKS_PER_BIT; inputs clk, reset, en; output tick. Counter clears when en=0. The FSM and shift register stay in the top module.

Test Plan:
- Defaults plus PARITY=0; msg_data="A" (0x41), MSG_LEN=1, GAP_FRAMES=0, pulse start -> uart_tx over 10 cycles = 0,1,0,0,0,0,0,1,0,1; busy high for exactly 10 cycles; done pulses at cycle 10.
- PARITY=2 then PARITY=1, same byte 0x41 -> parity bit 0 (even) / 1 (odd), placed after data bit 7; frame is 11 bits.
- CLKS_PER_BIT=4, STOP_BITS=2, 0x55 -> each bit held 4 cycles; frame = 44 cycles; two stop bits high.
- MSG_LEN=3 with bytes 0x01,0x02,0x03, GAP_FRAMES=2, loop=1 -> back-to-back frames, then 20 idle-high cycles. done pulses every 50 cycles; msg_addr sequence 0,1,2,0,...; drop loop -> exactly one more message, then IDLE.
- Second start pulse during frame 2 -> ignored: output identical to a single-start run; no extra message follows.
- Reset asserted mid DATA bit -> next cycle uart_tx=1, busy=0, msg_addr=0; a fresh start afterwards sends byte 0 correctly.

Source files
------------

// File: rtl/uart_msg_tx_pkg.sv
// Shared types and helpers for the UART message transmitter.
// Holds parity modes, the FSM state type and frame-length/parity functions.
package uart_msg_tx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_e;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Data is pre-masked to DATA_BITS, so the reduction covers only real data bits.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of every CLKS_PER_BIT window.
// The count is held at zero whenever en is low so each new bit starts aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Next count: wrap on tick, clear while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// UART message transmitter: streams MSG_LEN bytes fetched through msg_addr/msg_data,
// with start/busy/done handshake, optional inter-message gap and loop mode.
module uart_msg_tx
  import uart_msg_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSG_LEN      = 13,
  parameter int GAP_FRAMES   = 1,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop,
  input  logic [7:0]        msg_data,
  output logic [ADDR_W-1:0] msg_addr,
  output logic              busy,
  output logic              done,
  output logic              uart_tx
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int GAP_TOTAL  = GAP_FRAMES * FRAME_BITS;
  localparam int GAP_LAST   = (GAP_TOTAL > 0) ? GAP_TOTAL - 1 : 0;
  localparam int GAP_W      = $clog2(GAP_LAST + 1) + 1;
  localparam int BIT_W      = $clog2(DATA_BITS) + 1;

  localparam logic [7:0]        DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_LAST);

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              tick_s;
  logic              done_s;
  logic [7:0]        byte_s;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != S_IDLE),
    .tick  (tick_s)
  );

  assign byte_s = msg_data & DATA_MASK;

  // Next-state, counters and shift register.
  // The byte is captured on leaving START, when msg_addr already names it.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          bit_d   = '0;
          addr_d  = '0;
          shift_d = byte_s;
          par_d   = parity_bit(byte_s, PARITY);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_d = S_DATA;
          bit_d   = '0;
          shift_d = byte_s;
          par_d   = parity_bit(byte_s, PARITY);
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s && (bit_q == DATA_LAST)) begin
          bit_d   = '0;
          state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end else if (tick_s) begin
          bit_d   = bit_q + BIT_W'(1);
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          state_d = S_STOP;
          bit_d   = '0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (tick_s && (bit_q == STOP_LAST)) begin
          bit_d = '0;
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_START;
          end else if (GAP_FRAMES == 0) begin
            addr_d  = '0;
            done_s  = 1'b1;
            state_d = loop ? S_START : S_IDLE;
          end else begin
            addr_d  = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (tick_s) begin
          bit_d = bit_q + BIT_W'(1);
        end else begin
          state_d = S_STOP;
        end
      end
      S_GAP: begin
        if (tick_s && (gap_q == GAP_END)) begin
          gap_d   = '0;
          done_s  = 1'b1;
          state_d = loop ? S_START : S_IDLE;
        end else if (tick_s) begin
          gap_d = gap_q + GAP_W'(1);
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from next state so uart_tx is a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign msg_addr = addr_q;
  // done marks the final cycle of message+gap; it decodes registered state only.
  assign done     = done_s;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: five parameterisations checked against
// hand-computed frame tables and small per-cycle expectation models.
module tb_uart_msg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst0;
  logic       start_a, start_b, start_c, loop_c;
  logic [7:0] data_a, data_b, data_c;
  logic [4:0] tx, busy, done;
  logic [3:0] addr [5];

  int n_cmp = 0;
  int n_err = 0;

  assign data_c = {4'b0000, addr[4]} + 8'd1;

  uart_msg_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSG_LEN(1), .GAP_FRAMES(0), .ADDR_W(4)) u0 (
    .clk(clk), .reset(rst0), .start(start_a), .loop(1'b0), .msg_data(data_a),
    .msg_addr(addr[0]), .busy(busy[0]), .done(done[0]), .uart_tx(tx[0]));
  uart_msg_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MSG_LEN(1), .GAP_FRAMES(0), .ADDR_W(4)) u1 (
    .clk(clk), .reset(rst), .start(start_a), .loop(1'b0), .msg_data(data_a),
    .msg_addr(addr[1]), .busy(busy[1]), .done(done[1]), .uart_tx(tx[1]));
  uart_msg_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSG_LEN(1), .GAP_FRAMES(0), .ADDR_W(4)) u2 (
    .clk(clk), .reset(rst), .start(start_a), .loop(1'b0), .msg_data(data_a),
    .msg_addr(addr[2]), .busy(busy[2]), .done(done[2]), .uart_tx(tx[2]));
  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .MSG_LEN(1), .GAP_FRAMES(0), .ADDR_W(4)) u3 (
    .clk(clk), .reset(rst), .start(start_b), .loop(1'b0), .msg_data(data_b),
    .msg_addr(addr[3]), .busy(busy[3]), .done(done[3]), .uart_tx(tx[3]));
  uart_msg_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSG_LEN(3), .GAP_FRAMES(2), .ADDR_W(4)) u4 (
    .clk(clk), .reset(rst), .start(start_c), .loop(loop_c), .msg_data(data_c),
    .msg_addr(addr[4]), .busy(busy[4]), .done(done[4]), .uart_tx(tx[4]));

  // One stimulus/expectation row per cycle; bit i of each field belongs to u<i>.
  typedef struct {
    logic       start;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // 0x41 frames for u0 (no parity), u1 (even) and u2 (odd); mask selects checked DUTs.
  task automatic run_table(input logic [2:0] mask);
    for (int k = 0; k < 12; k++) begin
      start_a = vecs[k].start;
      cycle();
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          chk($sformatf("tbl_tx%0d", i), k, 32'(tx[i]), 32'(vecs[k].tx[i]));
          chk($sformatf("tbl_busy%0d", i), k, 32'(busy[i]), 32'(vecs[k].busy[i]));
          chk($sformatf("tbl_done%0d", i), k, 32'(done[i]), 32'(vecs[k].done[i]));
        end
      end
    end
    start_a = 1'b0;
  endtask

  initial begin
    logic       etx;
    logic [7:0] byt;
    int         b, f, mm;

    vecs[0]  = '{1'b1, 3'b000, 3'b111, 3'b000};
    vecs[1]  = '{1'b0, 3'b111, 3'b111, 3'b000};
    vecs[2]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[3]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[4]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[5]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[6]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[7]  = '{1'b0, 3'b111, 3'b111, 3'b000};
    vecs[8]  = '{1'b0, 3'b000, 3'b111, 3'b000};
    vecs[9]  = '{1'b0, 3'b101, 3'b111, 3'b001};
    vecs[10] = '{1'b0, 3'b111, 3'b110, 3'b110};
    vecs[11] = '{1'b0, 3'b111, 3'b000, 3'b000};

    rst = 1'b1; rst0 = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; loop_c = 1'b0;
    data_a = 8'h41; data_b = 8'h55;
    repeat (3) cycle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_tx%0d", i), 0, 32'(tx[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 0, 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 0, 32'(done[i]), 32'd0);
      chk($sformatf("rst_addr%0d", i), 0, 32'(addr[i]), 32'd0);
    end
    rst = 1'b0; rst0 = 1'b0;
    cycle();

    run_table(3'b111);
    repeat (3) cycle();

    // 4 clocks per bit, two stop bits, byte 0x55: 11 bits x 4 = 44 cycles.
    start_b = 1'b1;
    for (int c = 0; c <= 44; c++) begin
      cycle();
      start_b = 1'b0;
      b = c / 4;
      if (c >= 44)     etx = 1'b1;
      else if (b == 0) etx = 1'b0;
      else if (b <= 8) etx = data_b[b-1];
      else             etx = 1'b1;
      chk("cpb4_tx", c, 32'(tx[3]), 32'(etx));
      chk("cpb4_busy", c, 32'(busy[3]), 32'(c < 44));
      chk("cpb4_done", c, 32'(done[3]), 32'(c == 43));
    end

    // Three-byte looping message with a 20-cycle gap; stray start in frame 1,
    // loop dropped in the second message so exactly two messages are sent.
    start_c = 1'b1;
    loop_c  = 1'b1;
    for (int c = 0; c < 160; c++) begin
      cycle();
      start_c = (c == 14);
      if (c == 75) loop_c = 1'b0;
      mm = c % 50;
      if (c >= 100) begin
        etx = 1'b1; f = 0;
      end else if (mm < 30) begin
        f = mm / 10;
        b = mm % 10;
        byt = 8'(f + 1);
        if (b == 0)      etx = 1'b0;
        else if (b == 9) etx = 1'b1;
        else             etx = byt[b-1];
      end else begin
        etx = 1'b1; f = 0;
      end
      chk("msg_tx", c, 32'(tx[4]), 32'(etx));
      chk("msg_addr", c, 32'(addr[4]), 32'(f));
      chk("msg_busy", c, 32'(busy[4]), 32'(c < 100));
      chk("msg_done", c, 32'(done[4]), 32'((c < 100) && (mm == 49)));
    end
    start_c = 1'b0;

    // Reset in the middle of a data bit, then a clean resend of 0x41.
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
    rst0 = 1'b1;
    cycle();
    chk("midrst_tx", 0, 32'(tx[0]), 32'd1);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_addr", 0, 32'(addr[0]), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    rst0 = 1'b0;
    cycle();
    chk("post_rst_tx", 0, 32'(tx[0]), 32'd1);
    run_table(3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
